// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer: FSM states, result width,
// the "no best time yet" marker and the tick divider ratio helper.
package reaction_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } stateT;

  localparam int ELAPSED_W = 10;

  // All-ones means no completed measurement has been recorded yet.
  localparam logic [ELAPSED_W-1:0] BEST_INIT = 10'h3FF;

  // Clock cycles per tick; the integer division truncates.
  function automatic int divFor(input int clockFrequency, input int tickHz);
    return clockFrequency / tickHz;
  endfunction

endpackage

// File: rtl/reaction_timer_tick_divider.sv
// Tick generator for the reaction timer.
// tick pulses once every DIV cycles. restart zeroes the phase, so the
// first tick after a restart comes DIV cycles after the restart cycle.
module tick_divider #(
  parameter int DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  // Phase counter: wraps on the tick cycle and is cleared by restart.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (restart || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: measures ticks between a start pulse and a stop pulse,
// giving up at MAX_TICKS (timeout). Results stay on the outputs until the
// next start.
// Optional feature: define REACTION_TIMER_BEST_EN to add a best-time
// register (output best, input clear_best).
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int TICK_HZ         = 1000,
  parameter int MAX_TICKS       = 999
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
`ifdef REACTION_TIMER_BEST_EN
  input  logic                 clear_best,
  output logic [ELAPSED_W-1:0] best,
`endif
  output logic [ELAPSED_W-1:0] elapsed,
  output logic                 valid,
  output logic                 timeout,
  output logic                 busy
);

  localparam int DIV = divFor(CLOCK_FREQUENCY, TICK_HZ);
  localparam logic [ELAPSED_W-1:0] MAX_VALUE   = ELAPSED_W'(MAX_TICKS);
  localparam logic [ELAPSED_W-1:0] BEFORE_MAX  = ELAPSED_W'(MAX_TICKS - 1);

  stateT state;
  logic  tick;
  logic  restart;

  // A start only counts outside RUN, so only then does it re-phase the divider.
  assign restart = start && (state != RUN);

  tick_divider #(
    .DIV(DIV)
  ) divider (
    .clock  (clock),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Measurement FSM with registered outputs; stop has priority over a tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      elapsed <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (start) begin
            state   <= RUN;
            elapsed <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= HOLD;
            valid <= 1'b1;
            busy  <= 1'b0;
          end else if (tick) begin
            if (elapsed >= BEFORE_MAX) begin
              // This tick reaches the limit: saturate and flag timeout.
              state   <= HOLD;
              elapsed <= MAX_VALUE;
              timeout <= 1'b1;
              busy    <= 1'b0;
            end else begin
              elapsed <= elapsed + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef REACTION_TIMER_BEST_EN
  // Best time: captured together with valid when the new result is lower;
  // timeouts never reach this path because they do not come from stop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      best <= BEST_INIT;
    end else if (clear_best) begin
      best <= BEST_INIT;
    end else if ((state == RUN) && stop && (elapsed < best)) begin
      best <= elapsed;
    end
  end
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer (DIV=10, MAX_TICKS=5).
// Build with +define+REACTION_TIMER_BEST_EN to also check the best register.
module tb_reaction_timer;
  import reaction_timer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic stop  = 1'b0;
  logic [ELAPSED_W-1:0] elapsed;
  logic valid, timeout, busy;
`ifdef REACTION_TIMER_BEST_EN
  logic clearBest = 1'b0;
  logic [ELAPSED_W-1:0] best;
`endif

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [ELAPSED_W-1:0] elapsed;
    logic                 valid;
    logic                 timeout;
  } resultT;

  resultT expQ[$];

  always #5 clock = ~clock;

  reaction_timer #(
    .CLOCK_FREQUENCY(1000),
    .TICK_HZ        (100),
    .MAX_TICKS      (5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
`ifdef REACTION_TIMER_BEST_EN
    .clear_best(clearBest),
    .best      (best),
`endif
    .elapsed   (elapsed),
    .valid     (valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Start is sampled on the next edge ("edge 0"); returns 1 time unit after it.
  task automatic pulseStart();
    start = 1'b1;
    nextCycle();
    start = 1'b0;
  endtask

  // Stop sampled on the edgeN-th edge after the current one.
  task automatic stopAt(input int edgeN);
    repeat (edgeN - 1) nextCycle();
    stop = 1'b1;
    nextCycle();
    stop = 1'b0;
  endtask

  task automatic expectResult(input int e, input logic v, input logic t);
    resultT r;
    r.elapsed = ELAPSED_W'(e);
    r.valid   = v;
    r.timeout = t;
    expQ.push_back(r);
  endtask

  // Waits (bounded) for a finished result and compares it to the queue head.
  task automatic collect(input string tag);
    resultT r;
    int n = 0;
    while (!(valid || timeout) && n < 200) begin
      nextCycle();
      n++;
    end
    if (n >= 200) check({tag, "_wait"}, 32'd0, 32'd1);
    if (expQ.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      r = expQ.pop_front();
      $display("%s: elapsed=%0d valid=%0b timeout=%0b busy=%0b", tag, elapsed, valid, timeout, busy);
      check({tag, "_elapsed"}, 32'(elapsed), 32'(r.elapsed));
      check({tag, "_valid"},   32'(valid),   32'(r.valid));
      check({tag, "_timeout"}, 32'(timeout), 32'(r.timeout));
      check({tag, "_busy"},    32'(busy),    32'd0);
    end
  endtask

  task automatic measure(input string tag, input int stopEdge, input int e, input logic v, input logic t);
    expectResult(e, v, t);
    pulseStart();
    if (stopEdge > 0) stopAt(stopEdge);
    collect(tag);
  endtask

  task automatic doReset();
    #2 reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    nextCycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ELAPSED_W-1:0] held;

    // Reset state
    #2 reset = 1'b1;
    #1;
    check("reset_elapsed", 32'(elapsed), 32'd0);
    check("reset_valid",   32'(valid),   32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    check("reset_busy",    32'(busy),    32'd0);
`ifdef REACTION_TIMER_BEST_EN
    check("reset_best",    32'(best),    32'h3FF);
`endif
    nextCycle();
    reset = 1'b0;
    repeat (3) nextCycle();
    check("idle_busy", 32'(busy), 32'd0);

    // Stop while idle is ignored
    stop = 1'b1;
    nextCycle();
    stop = 1'b0;
    nextCycle();
    check("idle_stop_valid", 32'(valid), 32'd0);
    check("idle_stop_busy",  32'(busy),  32'd0);

    // Basic measurement: 35 cycles -> 3 ticks
    expectResult(3, 1'b1, 1'b0);
    pulseStart();
    check("run_busy", 32'(busy), 32'd1);
    stopAt(35);
    collect("stop35");

    // Stop in HOLD is ignored
    held = elapsed;
    stop = 1'b1;
    nextCycle();
    stop = 1'b0;
    nextCycle();
    check("hold_stop_elapsed", 32'(elapsed), 32'(held));
    check("hold_stop_valid",   32'(valid),   32'd1);

    // Stop coincident with the 2nd tick: stop wins
    measure("stop_on_tick", 20, 1, 1'b1, 1'b0);

    // Timeout with no stop, then elapsed stays saturated
    measure("timeout", 0, 5, 1'b0, 1'b1);
    repeat (20) nextCycle();
    check("timeout_hold_elapsed", 32'(elapsed), 32'd5);
    check("timeout_hold_flag",    32'(timeout), 32'd1);

    // Stop coincident with the timeout-causing tick: stop wins
    measure("stop_on_limit", 50, 4, 1'b1, 1'b0);

    // Start ignored in RUN
    expectResult(2, 1'b1, 1'b0);
    pulseStart();
    repeat (13) nextCycle();
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    check("restart_ignored_elapsed", 32'(elapsed), 32'd1);
    stopAt(10);
    collect("second_start");

    // Start and stop together in HOLD: start wins
    expectResult(1, 1'b1, 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    nextCycle();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy",  32'(busy),  32'd1);
    check("start_stop_valid", 32'(valid), 32'd0);
    stopAt(12);
    collect("start_with_stop");

    // Asynchronous reset mid-RUN at elapsed=2
    pulseStart();
    repeat (24) nextCycle();
    check("pre_reset_elapsed", 32'(elapsed), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("async_elapsed", 32'(elapsed), 32'd0);
    check("async_busy",    32'(busy),    32'd0);
    check("async_valid",   32'(valid),   32'd0);
    check("async_timeout", 32'(timeout), 32'd0);
    nextCycle();
    reset = 1'b0;
    repeat (15) nextCycle();
    check("post_reset_busy", 32'(busy), 32'd0);
    measure("after_reset", 15, 1, 1'b1, 1'b0);

`ifdef REACTION_TIMER_BEST_EN
    doReset();
    check("best_init", 32'(best), 32'h3FF);
    measure("best_r4", 45, 4, 1'b1, 1'b0);
    check("best_after_4", 32'(best), 32'd4);
    measure("best_r2", 25, 2, 1'b1, 1'b0);
    check("best_after_2", 32'(best), 32'd2);
    measure("best_to", 0, 5, 1'b0, 1'b1);
    check("best_after_timeout", 32'(best), 32'd2);
    measure("best_r3", 35, 3, 1'b1, 1'b0);
    check("best_after_3", 32'(best), 32'd2);
    clearBest = 1'b1;
    nextCycle();
    clearBest = 1'b0;
    check("best_cleared", 32'(best), 32'h3FF);
`endif

    check("queue_empty", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 50000000, SHALL set the input clock rate in Hz.
REQ-002 Parameter TICK_HZ, default 1000, SHALL set the count-up resolution (1 ms ticks).
REQ-003 Parameter MAX_TICKS, default 999, SHALL set the timeout limit in ticks; it SHALL be below 1024.
REQ-004 clock  input  1  Reset reset, asynchronous, active-high; clock clock.
REQ-005 reset  input  1  Asynchronous, active-high reset of all state.
REQ-006 start  input  1  Single-cycle pulse that begins a measurement (mole shown).
REQ-007 stop  input  1  Single-cycle pulse that ends a measurement (mole hit).
REQ-008 elapsed  output  10  Tick count since start, frozen after stop or timeout.
REQ-009 valid  output  1  High while elapsed holds a completed, non-timeout result.
REQ-010 timeout  output  1  High while the last measurement hit MAX_TICKS.
REQ-011 busy  output  1  High while measuring.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and HOLD; busy SHALL be 1 only in RUN.
REQ-013 On start in IDLE or HOLD, the next state SHALL be RUN, with elapsed=0, valid=0, timeout=0 and the divider restarted.
REQ-014 A start received in RUN SHALL be ignored.
REQ-015 The divider SHALL pulse tick once every DIV=CLOCK_FREQUENCY/TICK_HZ (integer) cycles; the first tick SHALL come DIV cycles after the start cycle.
REQ-016 In RUN, each tick SHALL increment elapsed by 1.
REQ-017 On stop in RUN, the next state SHALL be HOLD, with valid=1 on the next cycle and elapsed frozen.
REQ-018 If stop and tick occur in the same cycle, stop SHALL win and elapsed SHALL NOT increment.
REQ-019 A tick that makes elapsed equal MAX_TICKS SHALL move the FSM to HOLD with timeout=1 and valid=0 on the next cycle; elapsed SHALL saturate at MAX_TICKS.
REQ-020 If stop and the timeout-causing tick coincide, stop SHALL win, giving valid=1 and elapsed = MAX_TICKS-1.
REQ-021 A stop received in IDLE or HOLD SHALL be ignored.
REQ-022 If start and stop arrive together in IDLE or HOLD, start SHALL take effect and stop SHALL be ignored.
REQ-023 valid and timeout SHALL never both be 1.

Reset
REQ-024 Reset SHALL force state=IDLE, elapsed=0, valid=0, timeout=0, busy=0 and divider=0, with outputs changing immediately, including during RUN.
REQ-025 After reset deasserts, the block SHALL stay in IDLE until a start pulse.

Configuration
REQ-026 With macro REACTION_TIMER_BEST_EN defined, the block SHALL add output best (10 bits) and input clear_best (1 bit).
REQ-027 With REACTION_TIMER_BEST_EN, best SHALL reset to 10'h3FF.
REQ-028 With REACTION_TIMER_BEST_EN, on the cycle valid rises, best SHALL take elapsed if elapsed < best.
REQ-029 With REACTION_TIMER_BEST_EN, timeouts SHALL never update best, and clear_best SHALL set best to 10'h3FF on the next cycle.
REQ-030 Without REACTION_TIMER_BEST_EN, the ports and register SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/RUN/HOLD), ELAPSED_W=10 and BEST_INIT=10'h3FF.
REQ-032 Tick generation SHALL be a sub-module, tick_divider, with ports clock, reset, restart and tick.
REQ-033 The FSM, elapsed counter and best logic SHALL be in reaction_timer.

Verification (CLOCK_FREQUENCY=1000, TICK_HZ=100, so DIV=10; MAX_TICKS=5)
REQ-034 Start, then stop 35 cycles later -> elapsed=3, valid=1, timeout=0, busy=0.
REQ-035 Start with no stop -> after 50 cycles elapsed=5 and timeout=1, valid=0 the next cycle; elapsed stays at 5.
REQ-036 Stop on the same cycle as the 2nd tick -> elapsed=1, valid=1.
REQ-037 Reset asserted mid-RUN at elapsed=2 -> all outputs 0 at once; a later start measures from 0.
REQ-038 Start pulse during RUN at elapsed=1, then stop at cycle 25 -> elapsed=2 (second start ignored).
REQ-039 BEST_EN: results 4, then 2, then timeout, then 3 -> best=4, then 2, then 2, then 2; clear_best -> 10'h3FF.
